// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file sizing and the hardwired zero register index
package regfile_pkg;
  localparam int RF_DATA_W = 8;
  localparam int RF_ADDR_W = 3;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with set-over-clear priority and a registered busy count
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   set_en,
  input  logic [ADDR_W-1:0]      set_a,
  input  logic                   clr_en,
  input  logic [ADDR_W-1:0]      clr_a,
  output logic [2**ADDR_W-1:0]   busy_vec,
  output logic [ADDR_W:0]        busy_cnt
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DEPTH-1:0] nxt;
  logic [ADDR_W:0] cnt;
  always_comb begin
    nxt = busy_vec;
    if (clr_en) nxt[clr_a] = 1'b0;
    // a new writer issued on the writeback edge keeps the register pending
    if (set_en) nxt[set_a] = 1'b1;
    nxt[REG_ZERO] = 1'b0;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + {{ADDR_W{1'b0}}, nxt[i]};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      busy_vec <= '0;
      busy_cnt <= '0;
    end else begin
      busy_vec <= nxt;
      busy_cnt <= cnt;
    end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2R1W register file with zero register, busy-bit scoreboard and optional write-to-read bypass
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_wa,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   busy_cnt
);
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(REG_ZERO);
  logic [DATA_W-1:0] regs [2**ADDR_W];
  logic [2**ADDR_W-1:0] busy_vec;
  logic wr, byp1, byp2;
  assign wr = regwrite && wa != ZA;
  always_ff @(posedge clk or posedge reset)
    if (reset) regs <= '{default: '0};
    else if (wr) regs[wa] <= wd;
  regfile_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk(clk),
    .reset(reset),
    .set_en(issue_valid && issue_wa != ZA),
    .set_a(issue_wa),
    .clr_en(wr),
    .clr_a(wa),
    .busy_vec(busy_vec),
    .busy_cnt(busy_cnt)
  );
  always_comb begin
    byp1 = (BYPASS != 0) && wr && wa == ra1;
    byp2 = (BYPASS != 0) && wr && wa == ra2;
    rd1 = ra1 == ZA ? '0 : byp1 ? wd : regs[ra1];
    rd2 = ra2 == ZA ? '0 : byp2 ? wd : regs[ra2];
    busy1 = busy_vec[ra1] & ~byp1;
    busy2 = busy_vec[ra2] & ~byp2;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench driving a BYPASS=0 and a BYPASS=1 instance with shared directed stimulus
module tb_regfile_sb;
  logic clk = 0, reset = 0, regwrite = 0, issue_valid = 0;
  logic [2:0] wa = 0, ra1 = 0, ra2 = 0, issue_wa = 0;
  logic [7:0] wd = 0;
  logic [7:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic busy1_a, busy2_a, busy1_b, busy2_b;
  logic [3:0] cnt_a, cnt_b;
  int checks = 0, errors = 0;
  typedef struct { string nm; int dut; int sel; logic [7:0] v; } exp_t;
  exp_t q[$];
  localparam int RD1 = 0, RD2 = 1, B1 = 2, B2 = 3, CNT = 4;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(8), .ADDR_W(3), .BYPASS(0)) dut_a (
    .clk(clk), .reset(reset), .regwrite(regwrite), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
    .issue_valid(issue_valid), .issue_wa(issue_wa),
    .busy1(busy1_a), .busy2(busy2_a), .busy_cnt(cnt_a));
  regfile_sb #(.DATA_W(8), .ADDR_W(3), .BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .regwrite(regwrite), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .issue_valid(issue_valid), .issue_wa(issue_wa),
    .busy1(busy1_b), .busy2(busy2_b), .busy_cnt(cnt_b));

  function automatic logic [7:0] pick(int sel, logic [7:0] r1, logic [7:0] r2, logic b1, logic b2, logic [3:0] c);
    return sel == RD1 ? r1 : sel == RD2 ? r2 : sel == B1 ? {7'b0, b1} : sel == B2 ? {7'b0, b2} : {4'b0, c};
  endfunction

  always @(negedge clk)
    while (q.size() != 0) begin
      exp_t e;
      logic [7:0] act;
      e = q.pop_front();
      act = e.dut == 0 ? pick(e.sel, rd1_a, rd2_a, busy1_a, busy2_a, cnt_a)
                       : pick(e.sel, rd1_b, rd2_b, busy1_b, busy2_b, cnt_b);
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s bypass=%0d sel=%0d got %h expected %h", e.nm, e.dut, e.sel, act, e.v);
      end
    end

  task automatic e2(input string nm, input int sel, input logic [7:0] va, input logic [7:0] vb);
    q.push_back('{nm, 0, sel, va});
    q.push_back('{nm, 1, sel, vb});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      ra1 = 3'(i);
      ra2 = 3'(7 - i);
      e2("rst_rd1", RD1, 8'h00, 8'h00);
      e2("rst_rd2", RD2, 8'h00, 8'h00);
      e2("rst_busy1", B1, 8'h00, 8'h00);
      e2("rst_cnt", CNT, 8'h00, 8'h00);
    end
    step();
    reset = 0;
    step();
    regwrite = 1; wa = 3; wd = 8'hA5; ra1 = 3; ra2 = 0;
    e2("wr3_same_cycle", RD1, 8'h00, 8'hA5);
    step();
    regwrite = 0;
    e2("wr3_readback", RD1, 8'hA5, 8'hA5);
    step();
    regwrite = 1; wa = 0; wd = 8'hFF; ra1 = 0;
    e2("wr0_same_cycle", RD1, 8'h00, 8'h00);
    step();
    regwrite = 0;
    e2("wr0_readback", RD1, 8'h00, 8'h00);
    step();
    regwrite = 1; wa = 5; wd = 8'h3C; ra2 = 5;
    e2("byp5_rd2", RD2, 8'h00, 8'h3C);
    step();
    regwrite = 0;
    e2("wr5_readback", RD2, 8'h3C, 8'h3C);
    step();
    issue_valid = 1; issue_wa = 4; ra1 = 4;
    e2("issue4_no_fwd", B1, 8'h00, 8'h00);
    e2("issue4_cnt_before", CNT, 8'h00, 8'h00);
    step();
    issue_valid = 0;
    e2("raw4_busy1", B1, 8'h01, 8'h01);
    e2("raw4_cnt", CNT, 8'h01, 8'h01);
    e2("wr3_not_busy", B2, 8'h00, 8'h00);
    step();
    regwrite = 1; wa = 4; wd = 8'h77;
    e2("wb4_busy1", B1, 8'h01, 8'h00);
    e2("wb4_rd1", RD1, 8'h00, 8'h77);
    e2("wb4_cnt_before", CNT, 8'h01, 8'h01);
    step();
    regwrite = 0;
    e2("wb4_busy1_after", B1, 8'h00, 8'h00);
    e2("wb4_cnt_after", CNT, 8'h00, 8'h00);
    e2("wb4_rd1_after", RD1, 8'h77, 8'h77);
    step();
    issue_valid = 1; issue_wa = 6; regwrite = 1; wa = 6; wd = 8'h99; ra2 = 6;
    step();
    issue_valid = 0; regwrite = 0;
    e2("collide6_busy2", B2, 8'h01, 8'h01);
    e2("collide6_rd2", RD2, 8'h99, 8'h99);
    e2("collide6_cnt", CNT, 8'h01, 8'h01);
    step();
    issue_valid = 1; issue_wa = 6;
    step();
    issue_valid = 0;
    e2("waw6_busy2", B2, 8'h01, 8'h01);
    e2("waw6_cnt", CNT, 8'h01, 8'h01);
    step();
    regwrite = 1; wa = 6; wd = 8'h99; issue_valid = 1; issue_wa = 1;
    step();
    regwrite = 0; issue_wa = 2;
    e2("iss1_cnt", CNT, 8'h01, 8'h01);
    e2("clr6_busy2", B2, 8'h00, 8'h00);
    step();
    issue_wa = 7;
    e2("iss2_cnt", CNT, 8'h02, 8'h02);
    step();
    issue_valid = 0; ra1 = 7; ra2 = 1;
    e2("iss7_cnt", CNT, 8'h03, 8'h03);
    e2("iss7_busy1", B1, 8'h01, 8'h01);
    e2("iss1_busy2", B2, 8'h01, 8'h01);
    step();
    #2 reset = 1;
    e2("async_cnt", CNT, 8'h00, 8'h00);
    e2("async_busy1", B1, 8'h00, 8'h00);
    e2("async_busy2", B2, 8'h00, 8'h00);
    step();
    ra1 = 3; ra2 = 5;
    e2("rst_reg3", RD1, 8'h00, 8'h00);
    e2("rst_reg5", RD2, 8'h00, 8'h00);
    step();
    ra1 = 4; ra2 = 6;
    e2("rst_reg4", RD1, 8'h00, 8'h00);
    e2("rst_reg6", RD2, 8'h00, 8'h00);
    step();
    reset = 0;
    step();
    e2("post_rst_reg4", RD1, 8'h00, 8'h00);
    e2("post_rst_cnt", CNT, 8'h00, 8'h00);
    step();
    step();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a busy-bit scoreboard and optional write-to-read bypass, succeeding the 8-register, 8-bit file in the MIPS datapath. It provides two combinational read ports and one clocked write port. Register 0 is hardwired to zero. A per-register busy bit marks destinations of issued-but-not-written-back instructions (e.g. loads) so the hazard unit can stall on RAW dependencies. It sits between decode (reads, issue) and writeback (write).

## Interface
Parameters:
- DATA_W, 8, register width in bits
- ADDR_W, 3, register address width; depth = 2**ADDR_W
- BYPASS, 1, when 1, a same-cycle write is forwarded to the read ports and clears the busy indication

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all registers, busy bits and busy_cnt
- regwrite  in  1  writeback strobe
- wa  in  ADDR_W  write address
- wd  in  DATA_W  write data
- ra1, ra2  in  ADDR_W  read addresses (RS, RT)
- rd1, rd2  out  DATA_W  read data
- issue_valid  in  1  an instruction with a pending result is issued
- issue_wa  in  ADDR_W  destination of the issued instruction
- busy1, busy2  out  1  operand at ra1/ra2 has a pending write not yet available
- busy_cnt  out  ADDR_W+1  number of registers currently marked busy

## Operation
- Storage: array REGS[0 .. 2**ADDR_W-1] of DATA_W bits. Writes to address 0 are discarded; reads of address 0 return 0.
- Write: on a rising edge with regwrite=1 and wa≠0, REGS[wa] ← wd.
- Read rdN, for N in 1..2:
  - raN==0 → 0.
  - Else, if BYPASS=1 and regwrite=1 and wa==raN → wd.
  - Else → REGS[raN].
- Scoreboard: busy[0] is tied to 0. On a rising edge:
  - Writeback clears: regwrite=1 and wa≠0 → busy[wa] ← 0.
  - Issue sets: issue_valid=1 and issue_wa≠0 → busy[issue_wa] ← 1.
  - Set and clear to the same address in the same edge: the set wins, because a new writer is now pending.
  - Issue to an already-busy register (WAW) is legal. The bit stays 1; there is no reference counting.
- busyN output:
  - busyN = busy[raN] when BYPASS=0.
  - busyN = busy[raN] & ~(regwrite & wa==raN) when BYPASS=1.
- busy_cnt is a registered population count of busy[]. It updates on the same edge as busy[], using the next-state value. Range is 0 .. 2**ADDR_W-1.
- Writeback to a register that is not busy is legal: the data is written and busy is unaffected.

## Timing
- Reads and busyN are combinational from ra*, the registered state and the same-cycle write inputs. With BYPASS=1 the path from wa/wd to rd is combinational.
- Write latency: data is visible through the array one cycle after the write edge, and in the same cycle when BYPASS=1.
- Issue latency: busy becomes visible on busyN in the cycle after issue_valid. There is no same-cycle forwarding of issue into busyN.
- Reset, asserted at any time, including mid-issue:
  - REGS, busy[] and busy_cnt go to 0 immediately.
  - rd1/rd2 then show 0 unless bypassing.
  - busy1/busy2 go to 0.
- Inputs sampled during reset are ignored. The first update occurs on the first rising edge after deassertion.

## Structure
- Shared header/package regfile_pkg holds the default DATA_W and ADDR_W values and the constant REG_ZERO = 0, shared with the decoder and hazard unit.
- Sub-module regfile_scoreboard holds the busy[] vector, the set/clear priority logic and busy_cnt. Its ports are clk, reset, set_en, set_a, clr_en, clr_a, busy_vec and busy_cnt.
- The top level holds the data array, the read muxes and the bypass logic.

## Test plan
- Reset then read: reset asserted, then all ra values swept → rd=0x00, busy=0, busy_cnt=0.
- Write and read back (BYPASS=0):
  - Write wa=3, wd=0xA5; the next cycle ra1=3 → rd1=0xA5.
  - Write wa=0, wd=0xFF → rd of address 0 stays 0x00.
- Same-cycle bypass (BYPASS=1): regwrite=1, wa=5, wd=0x3C, with ra2=5 in the same cycle → rd2=0x3C before the edge.
- Scoreboard RAW:
  - Issue to 4, then ra1=4 → busy1=1, busy_cnt=1.
  - Writeback wa=4 with BYPASS=1 → busy1=0 in the writeback cycle.
  - busy_cnt=0 after the edge.
- Set/clear collision: issue_wa=6 and regwrite with wa=6 on the same edge → busy[6]=1 afterwards and REGS[6]=wd.
- Async reset mid-operation:
  - Issue to registers 1, 2 and 7 (busy_cnt=3).
  - Assert reset between edges → busy_cnt=0 and busy1=0 before the next edge, and all registers read 0.
